// File: rtl/audio_pkg.sv
// Shared constants, integrator type and saturation helper for the audio PDM output stage.
package audio_pkg;

    localparam logic [7:0] LEVEL_MID = 8'h80;
    localparam int         INT_W     = 12;
    localparam int         INT_MAX   = 2047;
    localparam int         INT_MIN   = -2048;
    localparam int         FB_MAG    = 128;

    typedef logic signed [INT_W-1:0] int_t;
    typedef logic signed [INT_W+1:0] acc_t;

    // Clamp a widened integrator sum back into the 12-bit signed range.
    function automatic int_t sat12(input acc_t v);
        if (v > acc_t'(INT_MAX)) begin
            return int_t'(INT_MAX);
        end else if (v < acc_t'(INT_MIN)) begin
            return int_t'(INT_MIN);
        end else begin
            return $signed(v[INT_W-1:0]);
        end
    endfunction

endpackage

// File: rtl/audio_pdm_out_if.sv
// DAC-side inputs and pin-side outputs of the audio PDM output stage.
interface audio_pdm_out_if;

    logic [7:0] dac_in;
    logic       mute;
    logic [1:0] vol;
    logic       sample_valid;
    logic [7:0] level_o;
    logic       audio_o;

    modport master (
        output dac_in,
        output mute,
        output vol,
        input  sample_valid,
        input  level_o,
        input  audio_o
    );

    modport slave (
        input  dac_in,
        input  mute,
        input  vol,
        output sample_valid,
        output level_o,
        output audio_o
    );

endinterface

// File: rtl/audio_pdm_out_ds2_mod.sv
// Second-order delta-sigma modulator: 8-bit level in, registered 1-bit stream out.
module ds2_mod
    import audio_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ce,
    input  logic [7:0] level,
    output logic       bit_o
);

    int_t int1;
    int_t int2;
    int_t int1_next;
    int_t int2_next;
    acc_t x;
    acc_t fb;

    always_comb begin
        x         = acc_t'($signed({1'b0, level})) - acc_t'(FB_MAG);
        fb        = bit_o ? acc_t'(FB_MAG) : -acc_t'(FB_MAG);
        // Second stage integrates the pre-update first-stage value.
        int1_next = sat12(acc_t'(int1) + x - fb);
        int2_next = sat12(acc_t'(int2) + acc_t'(int1) - fb);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            int1  <= '0;
            int2  <= '0;
            bit_o <= 1'b0;
        end else if (ce) begin
            int1  <= int1_next;
            int2  <= int2_next;
            bit_o <= (int2_next > int_t'(0));
        end
    end

endmodule

// File: rtl/audio_pdm_out.sv
// Audio output stage: DAC word capture, mute/volume, optional slew (AUDIO_SLEW_EN), delta-sigma out.
module audio_pdm_out
    import audio_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int CE_DIV        = 1
`ifdef AUDIO_SLEW_EN
    ,
    parameter int SLEW_DIV      = 64
`endif
) (
    input logic              clk,
    input logic              reset_n,
    audio_pdm_out_if.slave   bus
);

    localparam logic [3:0] STABLE_MAX  = 4'(STABLE_CYCLES);
    localparam logic [3:0] STABLE_LAST = 4'(STABLE_CYCLES - 1);
    localparam logic [7:0] CE_LAST     = 8'(CE_DIV - 1);

    logic [7:0]        s1;
    logic [7:0]        s2;
    logic [7:0]        held;
    logic [7:0]        target;
    logic [7:0]        level;
    logic [3:0]        cnt;
    logic [7:0]        ce_cnt;
    logic              ce;
    logic              accept;
    logic              sample_valid;
    logic              audio;
    logic signed [8:0] dev;
    logic signed [8:0] dev_sh;
    logic [8:0]        scaled;

    always_comb begin
        // Accept on the edge where the run of equal samples reaches STABLE_CYCLES.
        accept = (s1 == s2) && (cnt == STABLE_LAST) && (s2 != held);
        dev    = $signed({1'b0, held}) - 9'sd128;
        dev_sh = dev >>> bus.vol;
        scaled = dev_sh + 9'sd128;
        ce     = (ce_cnt == 8'd0);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1           <= LEVEL_MID;
            s2           <= LEVEL_MID;
            held         <= LEVEL_MID;
            cnt          <= 4'd0;
            sample_valid <= 1'b0;
        end else begin
            s1           <= bus.dac_in;
            s2           <= s1;
            sample_valid <= accept;
            if (s1 != s2) begin
                cnt <= 4'd0;
            end else if (cnt != STABLE_MAX) begin
                cnt <= cnt + 4'd1;
            end
            if (accept) begin
                held <= s2;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            target <= LEVEL_MID;
        end else begin
            target <= bus.mute ? LEVEL_MID : scaled[7:0];
        end
    end

`ifdef AUDIO_SLEW_EN
    localparam logic [9:0] SLEW_LAST = 10'(SLEW_DIV - 1);

    logic [9:0] slew_cnt;

    // Free-running step timer; a retarget only changes the direction of the next step.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            slew_cnt <= 10'd0;
            level    <= LEVEL_MID;
        end else if (slew_cnt == SLEW_LAST) begin
            slew_cnt <= 10'd0;
            if (level < target) begin
                level <= level + 8'd1;
            end else if (level > target) begin
                level <= level - 8'd1;
            end
        end else begin
            slew_cnt <= slew_cnt + 10'd1;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            level <= LEVEL_MID;
        end else begin
            level <= target;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ce_cnt <= 8'd0;
        end else if (ce_cnt == CE_LAST) begin
            ce_cnt <= 8'd0;
        end else begin
            ce_cnt <= ce_cnt + 8'd1;
        end
    end

    ds2_mod u_mod (
        .clk     (clk),
        .reset_n (reset_n),
        .ce      (ce),
        .level   (level),
        .bit_o   (audio)
    );

    assign bus.sample_valid = sample_valid;
    assign bus.level_o      = level;
    assign bus.audio_o      = audio;

endmodule

// File: tb/tb_audio_pdm_out.sv
// Bench for audio_pdm_out: directed tables and sequences plus randomized run against a behavioural model.
`timescale 1ns/1ps
module tb_audio_pdm_out;

    localparam int S   = 4;
    localparam int CE4 = 4;
`ifdef AUDIO_SLEW_EN
    localparam int SLEW = 2;
`endif

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #10 clk = ~clk;

    audio_pdm_out_if bus ();
    audio_pdm_out_if bus4 ();

    assign bus4.dac_in = bus.dac_in;
    assign bus4.mute   = bus.mute;
    assign bus4.vol    = bus.vol;

`ifdef AUDIO_SLEW_EN
    audio_pdm_out #(.STABLE_CYCLES(S), .CE_DIV(1), .SLEW_DIV(SLEW)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus));
    audio_pdm_out #(.STABLE_CYCLES(S), .CE_DIV(CE4), .SLEW_DIV(SLEW)) dut4 (
        .clk(clk), .reset_n(reset_n), .bus(bus4));
`else
    audio_pdm_out #(.STABLE_CYCLES(S), .CE_DIV(1)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus));
    audio_pdm_out #(.STABLE_CYCLES(S), .CE_DIV(CE4)) dut4 (
        .clk(clk), .reset_n(reset_n), .bus(bus4));
`endif

    int checks = 0;
    int errors = 0;

    // Behavioural model state: sample history, accepted word, pipeline levels, two modulators.
    byte unsigned hist[$];
    int m_held = 128, m_target = 128, m_level = 128, m_sv = 0, m_k = 0, m_rst = 1;
    int m_i1[2] = '{0, 0};
    int m_i2[2] = '{0, 0};
    int m_aud[2] = '{0, 0};
    int prev4 = 0, ce_bad = 0;

    function automatic int sat(input int v);
        if (v > 2047) return 2047;
        if (v < -2048) return -2048;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d..%0d at %0t", name, act, lo, hi, $time);
        end
    endtask

    task automatic model_step();
        int run, nlev, ntar, d, acc, x, fb, n1, n2;
        if (!reset_n) begin
            hist.delete();
            hist.push_back(8'h80);
            hist.push_back(8'h80);
            m_held = 128; m_target = 128; m_level = 128; m_sv = 0; m_k = 0; m_rst = 1;
            for (int i = 0; i < 2; i++) begin
                m_i1[i] = 0; m_i2[i] = 0; m_aud[i] = 0;
            end
            return;
        end
        m_rst = 0;
        m_k++;
        for (int i = 0; i < 2; i++) begin
            if (i == 0 || ((m_k - 1) % CE4) == 0) begin
                x  = m_level - 128;
                fb = (m_aud[i] != 0) ? 128 : -128;
                n1 = sat(m_i1[i] + x - fb);
                n2 = sat(m_i2[i] + m_i1[i] - fb);
                m_i1[i] = n1; m_i2[i] = n2; m_aud[i] = (n2 > 0) ? 1 : 0;
            end
        end
`ifdef AUDIO_SLEW_EN
        nlev = m_level;
        if ((m_k % SLEW) == 0) begin
            if (m_level < m_target) nlev = m_level + 1;
            else if (m_level > m_target) nlev = m_level - 1;
        end
`else
        nlev = m_target;
`endif
        d    = m_held - 128;
        ntar = bus.mute ? 128 : 128 + (d >>> bus.vol);
        // A word is taken once S+1 consecutive synchronized samples agree.
        run = 0;
        for (int i = hist.size() - 1; i > 0; i--) begin
            if (hist[i] == hist[i-1]) run++;
            else break;
        end
        acc = (run == S && int'(hist[hist.size()-2]) != m_held) ? 1 : 0;
        if (acc != 0) m_held = int'(hist[hist.size()-2]);
        m_sv = acc;
        hist.push_back(bus.dac_in);
        if (hist.size() > 24) void'(hist.pop_front());
        m_level  = nlev;
        m_target = ntar;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("model_level", int'(bus.level_o), m_level);
        check("model_sample_valid", int'(bus.sample_valid), m_sv);
        check("model_audio", int'(bus.audio_o), m_aud[0]);
        check("model_audio_ce4", int'(bus4.audio_o), m_aud[1]);
        if (m_rst == 0 && int'(bus4.audio_o) != prev4 && ((m_k - 1) % CE4) != 0) ce_bad++;
        prev4 = int'(bus4.audio_o);
    endtask

    typedef struct {
        logic [7:0] dac;
        logic [1:0] vol;
        logic       mute;
        logic [7:0] exp_level;
    } vec_t;

    typedef struct {
        logic [7:0] lvl;
        int         lo;
        int         hi;
    } dens_t;

    vec_t  vecs[9];
    dens_t dens[5];

    initial begin
        int pulses, ones, ones4, ones4_mid, n, mono, prev, peak, hold;

        vecs[0] = '{8'h00, 2'd0, 1'b0, 8'h00};
        vecs[1] = '{8'h00, 2'd1, 1'b0, 8'h40};
        vecs[2] = '{8'h00, 2'd2, 1'b0, 8'h60};
        vecs[3] = '{8'h00, 2'd3, 1'b0, 8'h70};
        vecs[4] = '{8'hFF, 2'd1, 1'b0, 8'hBF};
        vecs[5] = '{8'hFF, 2'd0, 1'b0, 8'hFF};
        vecs[6] = '{8'hFF, 2'd3, 1'b0, 8'h8F};
        vecs[7] = '{8'hC0, 2'd1, 1'b0, 8'hA0};
        vecs[8] = '{8'h40, 2'd2, 1'b1, 8'h80};

        dens[0] = '{8'h00, 0, 0};
        dens[1] = '{8'h40, 1020, 1028};
        dens[2] = '{8'h80, 2044, 2052};
        dens[3] = '{8'hC0, 3068, 3076};
        dens[4] = '{8'hFF, 4064, 4096};

        // Reset with a non-silent word on the input.
        bus.dac_in = 8'h3C; bus.mute = 1'b0; bus.vol = 2'd0; reset_n = 1'b0;
        repeat (3) tick();
        check("reset_level", int'(bus.level_o), 8'h80);
        check("reset_audio", int'(bus.audio_o), 0);
        check("reset_sample_valid", int'(bus.sample_valid), 0);
        reset_n = 1'b1;
        pulses = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            pulses += int'(bus.sample_valid);
`ifndef AUDIO_SLEW_EN
            if (k == S + 3) check("latency_before", int'(bus.level_o), 8'h80);
            if (k == S + 4) check("latency_at", int'(bus.level_o), 8'h3C);
`endif
        end
        check("reset_release_pulses", pulses, 1);

        // Glitches of S-1 and S samples are dropped; S+1 samples is enough to be taken.
        bus.dac_in = 8'h80;
        repeat (12) tick();
        for (int g = 3; g <= 5; g++) begin
            pulses = 0;
            bus.dac_in = 8'h20;
            for (int k = 0; k < g; k++) begin tick(); pulses += int'(bus.sample_valid); end
            bus.dac_in = 8'h80;
            for (int k = 0; k < 14; k++) begin tick(); pulses += int'(bus.sample_valid); end
            check($sformatf("glitch_len%0d_pulses", g), pulses, (g > S) ? 2 : 0);
`ifndef AUDIO_SLEW_EN
            check($sformatf("glitch_len%0d_level", g), int'(bus.level_o), 8'h80);
`endif
        end

        // Volume / mute table.
        for (int i = 0; i < 9; i++) begin
            bus.dac_in = vecs[i].dac; bus.vol = vecs[i].vol; bus.mute = vecs[i].mute;
`ifdef AUDIO_SLEW_EN
            repeat (S + 6 + 300) tick();
`else
            repeat (S + 6) tick();
`endif
            check($sformatf("vol_vec%0d", i), int'(bus.level_o), int'(vecs[i].exp_level));
        end

        // Mute lands two clocks after assertion.
        bus.dac_in = 8'h00; bus.vol = 2'd0; bus.mute = 1'b0;
`ifdef AUDIO_SLEW_EN
        repeat (300) tick();
`else
        repeat (S + 6) tick();
`endif
        check("mute_pre", int'(bus.level_o), 8'h00);
        bus.mute = 1'b1;
        tick();
`ifndef AUDIO_SLEW_EN
        check("mute_one_clock", int'(bus.level_o), 8'h00);
        tick();
        check("mute_two_clocks", int'(bus.level_o), 8'h80);
`endif

        // Accept and mute on the same edge: word is taken, mute still owns the target.
        bus.mute = 1'b0;
        repeat (300) tick();
        bus.dac_in = 8'hC0;
        repeat (S + 1) tick();
        bus.mute = 1'b1;
        tick();
        check("simul_accept_pulse", int'(bus.sample_valid), 1);
`ifndef AUDIO_SLEW_EN
        repeat (3) tick();
        check("simul_mute_wins", int'(bus.level_o), 8'h80);
        bus.mute = 1'b0;
        tick(); tick();
        check("simul_unmute_level", int'(bus.level_o), 8'hC0);
`endif
        bus.mute = 1'b0;

        // Density of ones over 4096 modulator updates.
        ones4_mid = 0;
        for (int i = 0; i < 5; i++) begin
            bus.dac_in = dens[i].lvl; bus.vol = 2'd0; bus.mute = 1'b0;
            repeat (600) tick();
            check($sformatf("density_level_%0h", dens[i].lvl), int'(bus.level_o), int'(dens[i].lvl));
            ones = 0; ones4 = 0;
            for (int k = 0; k < 4096; k++) begin
                tick();
                ones  += int'(bus.audio_o);
                ones4 += int'(bus4.audio_o);
            end
            check_range($sformatf("density_%0h", dens[i].lvl), ones, dens[i].lo, dens[i].hi);
            if (i == 2) ones4_mid = ones4;
        end
        check_range("density_ce4_80", ones4_mid, 2048 - 16, 2048 + 16);

        // Reset mid-stream clears the bitstream on the same edge.
        bus.dac_in = 8'hC0;
        repeat (200) tick();
        reset_n = 1'b0;
        tick();
        check("midreset_audio", int'(bus.audio_o), 0);
        check("midreset_audio_ce4", int'(bus4.audio_o), 0);
        check("midreset_level", int'(bus.level_o), 8'h80);
        reset_n = 1'b1;
        repeat (40) tick();

`ifdef AUDIO_SLEW_EN
        // Slew ramp 0x80 -> 0x90, then mute mid-ramp.
        bus.dac_in = 8'h80; bus.vol = 2'd0; bus.mute = 1'b0;
        repeat (600) tick();
        bus.dac_in = 8'h90;
        n = 0; mono = 1; prev = int'(bus.level_o);
        while (int'(bus.level_o) != 8'h90 && n < 100) begin
            tick();
            if (int'(bus.level_o) < prev) mono = 0;
            prev = int'(bus.level_o);
            n++;
        end
        check("slew_reach_90", int'(bus.level_o), 8'h90);
        check_range("slew_ramp_clocks", n, 32, 32 + S + 4);
        check("slew_monotonic", mono, 1);
        bus.dac_in = 8'h80;
        repeat (100) tick();
        bus.dac_in = 8'h90;
        n = 0;
        while (int'(bus.level_o) != 8'h88 && n < 100) begin tick(); n++; end
        check("slew_reach_88", int'(bus.level_o), 8'h88);
        bus.mute = 1'b1;
        n = 0; peak = int'(bus.level_o);
        while (int'(bus.level_o) != 8'h80 && n < 100) begin
            tick();
            if (int'(bus.level_o) > peak) peak = int'(bus.level_o);
            n++;
        end
        check("slew_mute_back_80", int'(bus.level_o), 8'h80);
        check_range("slew_mute_peak", peak, 8'h88, 8'h89);
        bus.mute = 1'b0;
`endif

        // Randomized traffic, compared cycle by cycle against the model.
        hold = 0;
        for (int k = 0; k < 4000; k++) begin
            if (hold == 0) begin
                bus.dac_in = 8'($urandom_range(0, 255));
                hold = $urandom_range(1, 9);
            end
            hold--;
            if ($urandom_range(0, 63) == 0) bus.mute = ~bus.mute;
            if ($urandom_range(0, 99) == 0) bus.vol = 2'($urandom_range(0, 3));
            reset_n = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
            tick();
        end
        reset_n = 1'b1;
        repeat (4) tick();

        check("ce4_changes_only_on_ce", ce_bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
